// File: rtl/tprx_fsm.sv
// Transport-layer receive FSM: decodes incoming FIS dwords from the link layer,
// forwards control/data dwords to the application and reports FIS status.
module tprx_fsm (
    input  logic        clk,
    input  logic        tprx_reset_n,
    input  logic        lk_rxvalid,
    input  logic [31:0] lk_rxdata,
    input  logic        lk_rxsof,
    input  logic        lk_rxeof,
    input  logic        lk_rxcrcerr,
    input  logic        a2t_dready,
    output logic        t2l_rxready,
    output logic        t2l_rxgood,
    output logic        t2l_rxbad,
    output logic [2:0]  t2a_fistype,
    output logic        t2a_fisvalid,
    output logic        t2a_fiserr,
    output logic        t2a_dvalid,
    output logic [31:0] t2a_data,
    output logic [11:0] t2a_dwcnt,
    output logic        r2t_rxempty,
    output logic        r2t_waittxid,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CTRL  = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_STAT  = 3'd4
    } state_t;

    localparam logic [2:0]  TYPE_DMAACT = 3'd2;
    localparam logic [2:0]  TYPE_DATA   = 3'd6;
    localparam logic [11:0] DATA_MAXIDX = 12'd2048;

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic [2:0]  fistype_q, fistype_d;
    logic [2:0]  explen_q, explen_d;
    logic [11:0] dwcnt_q, dwcnt_d;
    logic [31:0] data_q, data_d;
    logic        dvalid_q, dvalid_d;
    logic        rxgood_q, rxgood_d;
    logic        rxbad_q, rxbad_d;
    logic        fisvalid_q, fisvalid_d;
    logic        fiserr_q, fiserr_d;
    logic        waittxid_q, waittxid_d;

    logic        acc;
    logic [2:0]  dec_type;
    logic [2:0]  dec_len;
    logic [11:0] nxt_idx;
    logic        cnt_ovf;
    logic [11:0] last_idx;
    logic        go_stat;
    logic        fin_err;
    logic        fis_good;

    always_comb begin
        dec_type = 3'd0;
        dec_len  = 3'd0;
        case (lk_rxdata[7:0])
            8'h34:   begin dec_type = 3'd1; dec_len = 3'd5; end
            8'h39:   begin dec_type = 3'd2; dec_len = 3'd1; end
            8'h5F:   begin dec_type = 3'd3; dec_len = 3'd5; end
            8'h41:   begin dec_type = 3'd4; dec_len = 3'd7; end
            8'h58:   begin dec_type = 3'd5; dec_len = 3'd3; end
            8'h46:   begin dec_type = 3'd6; dec_len = 3'd0; end
            8'hA1:   begin dec_type = 3'd7; dec_len = 3'd2; end
            default: begin dec_type = 3'd0; dec_len = 3'd0; end
        endcase
    end

    // Readiness is a pure state decode so the link sees it in the same cycle.
    always_comb begin
        t2l_rxready = 1'b1;
        if (state_q == S_DATA)
            t2l_rxready = a2t_dready;
        else if (state_q == S_STAT)
            t2l_rxready = 1'b0;
    end

    assign r2t_rxempty = (state_q == S_IDLE);
    assign acc         = lk_rxvalid & t2l_rxready;
    assign cnt_ovf     = (dwcnt_q == 12'hFFF);
    assign nxt_idx     = cnt_ovf ? 12'hFFF : dwcnt_q + 12'd1;
    assign last_idx    = {9'd0, explen_q} - 12'd1;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        fistype_d  = fistype_q;
        explen_d   = explen_q;
        dwcnt_d    = dwcnt_q;
        data_d     = data_q;
        dvalid_d   = 1'b0;
        rxgood_d   = 1'b0;
        rxbad_d    = 1'b0;
        fisvalid_d = 1'b0;
        fiserr_d   = 1'b0;
        waittxid_d = 1'b0;
        go_stat    = 1'b0;
        fin_err    = 1'b0;
        fis_good   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc && lk_rxsof) begin
                    fistype_d = dec_type;
                    explen_d  = dec_len;
                    dwcnt_d   = 12'd0;
                    err_d     = 1'b0;
                    if (dec_type == 3'd0) begin
                        err_d = 1'b1;
                        if (lk_rxeof) begin
                            go_stat = 1'b1;
                            fin_err = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else if (dec_type == TYPE_DATA) begin
                        if (lk_rxeof) begin
                            go_stat = 1'b1;
                            fin_err = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        dvalid_d = 1'b1;
                        data_d   = lk_rxdata;
                        if (lk_rxeof) begin
                            go_stat = 1'b1;
                            fin_err = (dec_len != 3'd1);
                        end else if (dec_len == 3'd1) begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_CTRL;
                        end
                    end
                end
            end
            S_CTRL: begin
                if (acc) begin
                    if (lk_rxsof) begin
                        go_stat = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        dwcnt_d  = nxt_idx;
                        dvalid_d = 1'b1;
                        data_d   = lk_rxdata;
                        if (lk_rxeof) begin
                            go_stat = 1'b1;
                            fin_err = err_q | cnt_ovf | (nxt_idx != last_idx);
                        end else if (nxt_idx == last_idx) begin
                            // Expected length reached without eof: drop the rest.
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    if (lk_rxsof) begin
                        go_stat = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        dwcnt_d = nxt_idx;
                        if (nxt_idx <= DATA_MAXIDX) begin
                            dvalid_d = 1'b1;
                            data_d   = lk_rxdata;
                        end
                        if (lk_rxeof) begin
                            go_stat = 1'b1;
                            fin_err = err_q | (nxt_idx > DATA_MAXIDX);
                        end else if (nxt_idx > DATA_MAXIDX) begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (acc) begin
                    if (lk_rxsof) begin
                        go_stat = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        dwcnt_d = nxt_idx;
                        if (cnt_ovf)
                            err_d = 1'b1;
                        if (lk_rxeof) begin
                            go_stat = 1'b1;
                            fin_err = 1'b1;
                        end
                    end
                end
            end
            S_STAT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status pulses are registered on entry so they coincide with the STAT cycle.
        if (go_stat) begin
            state_d    = S_STAT;
            fis_good   = ~(fin_err | (lk_rxeof & lk_rxcrcerr));
            rxgood_d   = fis_good;
            fisvalid_d = fis_good;
            rxbad_d    = ~fis_good;
            fiserr_d   = ~fis_good;
            waittxid_d = fis_good & (fistype_d == TYPE_DMAACT);
        end
    end

    always_ff @(posedge clk or negedge tprx_reset_n) begin
        if (!tprx_reset_n) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            fistype_q  <= 3'd0;
            explen_q   <= 3'd0;
            dwcnt_q    <= 12'd0;
            data_q     <= 32'd0;
            dvalid_q   <= 1'b0;
            rxgood_q   <= 1'b0;
            rxbad_q    <= 1'b0;
            fisvalid_q <= 1'b0;
            fiserr_q   <= 1'b0;
            waittxid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            fistype_q  <= fistype_d;
            explen_q   <= explen_d;
            dwcnt_q    <= dwcnt_d;
            data_q     <= data_d;
            dvalid_q   <= dvalid_d;
            rxgood_q   <= rxgood_d;
            rxbad_q    <= rxbad_d;
            fisvalid_q <= fisvalid_d;
            fiserr_q   <= fiserr_d;
            waittxid_q <= waittxid_d;
        end
    end

    assign t2l_rxgood   = rxgood_q;
    assign t2l_rxbad    = rxbad_q;
    assign t2a_fistype  = fistype_q;
    assign t2a_fisvalid = fisvalid_q;
    assign t2a_fiserr   = fiserr_q;
    assign t2a_dvalid   = dvalid_q;
    assign t2a_data     = data_q;
    assign t2a_dwcnt    = dwcnt_q;
    assign r2t_waittxid = waittxid_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_tprx_fsm.sv
// Bench for tprx_fsm: directed FIS sequences, a FIS-level reference model
// feeding beat/status queues, and one negedge compare process.
module tb_tprx_fsm;

    logic        clk = 1'b0;
    logic        tprx_reset_n;
    logic        lk_rxvalid;
    logic [31:0] lk_rxdata;
    logic        lk_rxsof;
    logic        lk_rxeof;
    logic        lk_rxcrcerr;
    logic        a2t_dready;
    logic        t2l_rxready;
    logic        t2l_rxgood;
    logic        t2l_rxbad;
    logic [2:0]  t2a_fistype;
    logic        t2a_fisvalid;
    logic        t2a_fiserr;
    logic        t2a_dvalid;
    logic [31:0] t2a_data;
    logic [11:0] t2a_dwcnt;
    logic        r2t_rxempty;
    logic        r2t_waittxid;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    tprx_fsm dut (
        .clk          (clk),
        .tprx_reset_n (tprx_reset_n),
        .lk_rxvalid   (lk_rxvalid),
        .lk_rxdata    (lk_rxdata),
        .lk_rxsof     (lk_rxsof),
        .lk_rxeof     (lk_rxeof),
        .lk_rxcrcerr  (lk_rxcrcerr),
        .a2t_dready   (a2t_dready),
        .t2l_rxready  (t2l_rxready),
        .t2l_rxgood   (t2l_rxgood),
        .t2l_rxbad    (t2l_rxbad),
        .t2a_fistype  (t2a_fistype),
        .t2a_fisvalid (t2a_fisvalid),
        .t2a_fiserr   (t2a_fiserr),
        .t2a_dvalid   (t2a_dvalid),
        .t2a_data     (t2a_data),
        .t2a_dwcnt    (t2a_dwcnt),
        .r2t_rxempty  (r2t_rxempty),
        .r2t_waittxid (r2t_waittxid),
        .dbg_state    (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // Expected beats {dwcnt, data}; expected status {good, waittxid, fistype}.
    logic [43:0] exp_q[$];
    logic [4:0]  stat_q[$];

    int n_good  = 0;
    int n_bad   = 0;
    int n_wait  = 0;
    int n_beats = 0;
    int to_cnt  = 0;
    int to_seen = 0;
    bit in_data   = 1'b0;
    bit toggle_en = 1'b0;
    bit done      = 1'b0;
    bit stat_prev = 1'b0;
    int tog_idx   = 0;

    function automatic logic [31:0] dw_of(input logic [7:0] code, input int i);
        logic [15:0] lo;
        lo = i[15:0];
        if (i == 0)
            return {24'h00A5A5, code};
        return {code, 8'h3C, lo};
    endfunction

    // Application back-pressure: 1,0,1 repeating when enabled, otherwise always ready.
    initial begin
        a2t_dready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) begin
                a2t_dready = ((tog_idx % 3) != 1);
                tog_idx++;
            end else begin
                a2t_dready = 1'b1;
            end
        end
    end

    // Present one dword and hold it until the DUT accepts it at a rising edge.
    task automatic send_dw(input logic [31:0] d, input logic sof, input logic eof,
                           input logic crc);
        bit seen;
        lk_rxvalid  = 1'b1;
        lk_rxdata   = d;
        lk_rxsof    = sof;
        lk_rxeof    = eof;
        lk_rxcrcerr = crc;
        seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (t2l_rxready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            to_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input int cycles);
        lk_rxvalid  = 1'b0;
        lk_rxsof    = 1'b0;
        lk_rxeof    = 1'b0;
        lk_rxcrcerr = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // FIS-level model: what the application and link must see for a whole FIS.
    task automatic model_fis(input logic [7:0] code, input int n, input bit crc);
        logic [2:0] typ;
        int         len;
        int         m;
        bit         good;
        typ = 3'd0;
        len = 0;
        case (code)
            8'h34: begin typ = 3'd1; len = 5; end
            8'h39: begin typ = 3'd2; len = 1; end
            8'h5F: begin typ = 3'd3; len = 5; end
            8'h41: begin typ = 3'd4; len = 7; end
            8'h58: begin typ = 3'd5; len = 3; end
            8'h46: begin typ = 3'd6; len = 0; end
            8'hA1: begin typ = 3'd7; len = 2; end
            default: begin typ = 3'd0; len = 0; end
        endcase
        if (typ == 3'd0) begin
            good = 1'b0;
        end else if (typ == 3'd6) begin
            m = (n - 1 < 2048) ? n - 1 : 2048;
            for (int i = 1; i <= m; i++)
                exp_q.push_back({12'(i), dw_of(code, i)});
            good = (n >= 2) && (n <= 2049) && !crc;
        end else begin
            m = (n < len) ? n : len;
            for (int i = 0; i < m; i++)
                exp_q.push_back({12'(i), dw_of(code, i)});
            good = (n == len) && !crc;
        end
        stat_q.push_back({good, good && (typ == 3'd2), typ});
    endtask

    task automatic send_fis(input logic [7:0] code, input int n, input bit crc);
        model_fis(code, n, crc);
        for (int i = 0; i < n; i++) begin
            send_dw(dw_of(code, i), (i == 0), (i == n - 1), crc && (i == n - 1));
            in_data = (code == 8'h46) && (i != n - 1);
        end
        go_idle(4);
    endtask

    // Data FIS cut by reset after index 100: beats up to 100 then nothing.
    task automatic reset_mid_data();
        for (int i = 1; i <= 100; i++)
            exp_q.push_back({12'(i), dw_of(8'h46, i)});
        for (int i = 0; i <= 100; i++) begin
            send_dw(dw_of(8'h46, i), (i == 0), 1'b0, 1'b0);
            in_data = 1'b1;
        end
        in_data    = 1'b0;
        lk_rxvalid = 1'b0;
        @(negedge clk);
        #1 tprx_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 tprx_reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_dw(32'hDEAD0034, 1'b0, 1'b0, 1'b0);
        send_dw(32'hBEEF0039, 1'b0, 1'b1, 1'b0);
        go_idle(3);
    endtask

    always @(negedge clk) begin
        logic [43:0] e;
        logic [4:0]  s;
        bit          any_stat;
        if (!tprx_reset_n) begin
            checks++;
            if (t2a_dvalid || t2l_rxgood || t2l_rxbad || t2a_fisvalid || t2a_fiserr ||
                r2t_waittxid || t2a_fistype != 3'd0 || t2a_dwcnt != 12'd0 ||
                t2a_data != 32'd0 || r2t_rxempty !== 1'b1) begin
                failures++;
                $display("FAIL reset_state: dvalid=%0b good=%0b bad=%0b fv=%0b fe=%0b wt=%0b type=%0d cnt=%0d data=%h empty=%0b, required all zero with empty=1",
                         t2a_dvalid, t2l_rxgood, t2l_rxbad, t2a_fisvalid, t2a_fiserr,
                         r2t_waittxid, t2a_fistype, t2a_dwcnt, t2a_data, r2t_rxempty);
            end
            stat_prev = 1'b0;
        end else begin
            if (t2a_dvalid) begin
                n_beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected: got cnt=%0d data=%h, required no beat",
                             t2a_dwcnt, t2a_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({t2a_dwcnt, t2a_data} !== e) begin
                        failures++;
                        $display("FAIL beat: got cnt=%0d data=%h, required cnt=%0d data=%h",
                                 t2a_dwcnt, t2a_data, e[43:32], e[31:0]);
                    end
                end
            end
            any_stat = t2l_rxgood | t2l_rxbad | t2a_fisvalid | t2a_fiserr | r2t_waittxid;
            if (any_stat) begin
                checks++;
                if (stat_q.size() == 0) begin
                    failures++;
                    $display("FAIL status_unexpected: good=%0b bad=%0b fv=%0b fe=%0b wt=%0b, required none",
                             t2l_rxgood, t2l_rxbad, t2a_fisvalid, t2a_fiserr, r2t_waittxid);
                end else begin
                    s = stat_q.pop_front();
                    if ({t2l_rxgood, t2l_rxbad, t2a_fisvalid, t2a_fiserr, r2t_waittxid,
                         t2a_fistype, t2l_rxready} !== {s[4], ~s[4], s[4], ~s[4], s[3], s[2:0], 1'b0}) begin
                        failures++;
                        $display("FAIL status: good=%0b bad=%0b fv=%0b fe=%0b wt=%0b type=%0d rdy=%0b, required good=%0b wt=%0b type=%0d rdy=0",
                                 t2l_rxgood, t2l_rxbad, t2a_fisvalid, t2a_fiserr, r2t_waittxid,
                                 t2a_fistype, t2l_rxready, s[4], s[3], s[2:0]);
                    end
                end
                if (t2l_rxgood) n_good++;
                if (t2l_rxbad) n_bad++;
                if (r2t_waittxid) n_wait++;
            end
            if (stat_prev) begin
                checks++;
                if (r2t_rxempty !== 1'b1 || t2l_rxready !== 1'b1) begin
                    failures++;
                    $display("FAIL after_status: empty=%0b rdy=%0b, required empty=1 rdy=1",
                             r2t_rxempty, t2l_rxready);
                end
            end
            stat_prev = any_stat;
            if (in_data) begin
                checks++;
                if (t2l_rxready !== a2t_dready) begin
                    failures++;
                    $display("FAIL data_ready: rdy=%0b, required %0b", t2l_rxready, a2t_dready);
                end
            end
        end
        if (to_cnt != to_seen) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: dword not accepted within 64 cycles (count %0d)", to_cnt);
            to_seen = to_cnt;
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0 || stat_q.size() != 0) begin
                failures++;
                $display("FAIL leftover: beats=%0d status=%0d, required 0 and 0",
                         exp_q.size(), stat_q.size());
            end
            checks++;
            if (n_good != 4 || n_bad != 3 || n_wait != 1) begin
                failures++;
                $display("FAIL status_totals: good=%0d bad=%0d wait=%0d, required 4 3 1",
                         n_good, n_bad, n_wait);
            end
            checks++;
            if (n_beats != 128) begin
                failures++;
                $display("FAIL beat_total: got %0d, required 128", n_beats);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        tprx_reset_n = 1'b0;
        lk_rxvalid   = 1'b0;
        lk_rxdata    = 32'd0;
        lk_rxsof     = 1'b0;
        lk_rxeof     = 1'b0;
        lk_rxcrcerr  = 1'b0;
        repeat (3) @(posedge clk);
        #1 tprx_reset_n = 1'b1;
        go_idle(2);

        send_fis(8'h34, 5, 1'b0);
        send_fis(8'h39, 1, 1'b0);
        tog_idx   = 0;
        toggle_en = 1'b1;
        send_fis(8'h46, 9, 1'b0);
        toggle_en = 1'b0;
        send_fis(8'h12, 4, 1'b0);
        send_fis(8'h5F, 4, 1'b0);
        send_fis(8'h34, 5, 1'b1);
        reset_mid_data();
        send_fis(8'h34, 5, 1'b0);

        go_idle(3);
        done = 1'b1;
        repeat (20) @(posedge clk);
        $display("FAIL end_of_run: compare process did not finish");
        $fatal(1);
    end

endmodule

// File: doc/tprx_fsm.md
TPRX_FSM -- requirements
Module: tprx_fsm

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-002 SHALL have port tprx_reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port lk_rxvalid, input, 1: link-layer dword valid.
REQ-004 SHALL have port lk_rxdata, input, 32: received FIS dword.
REQ-005 SHALL have port lk_rxsof, input, 1: first dword of FIS, qualified by lk_rxvalid.
REQ-006 SHALL have port lk_rxeof, input, 1: last dword of FIS, qualified by lk_rxvalid.
REQ-007 SHALL have port lk_rxcrcerr, input, 1: CRC bad, qualified by lk_rxeof.
REQ-008 SHALL have port a2t_dready, input, 1: application can accept a data dword.
REQ-009 SHALL have port t2l_rxready, output, 1: transport consumes the current dword when lk_rxvalid=1.
REQ-010 SHALL have port t2l_rxgood, output, 1: one-cycle pulse requesting R_OK.
REQ-011 SHALL have port t2l_rxbad, output, 1: one-cycle pulse requesting R_ERR.
REQ-012 SHALL have port t2a_fistype, output, 3: 1=RegD2H, 2=DMAAct, 3=PIOSetup, 4=DMASetup, 5=BIST, 6=Data, 7=SDB, 0=none.
REQ-013 SHALL have port t2a_fisvalid, output, 1: one-cycle pulse; FIS complete and good.
REQ-014 SHALL have port t2a_fiserr, output, 1: one-cycle pulse; FIS bad.
REQ-015 SHALL have port t2a_dvalid, output, 1: t2a_data valid.
REQ-016 SHALL have port t2a_data, output, 32: registered payload or control dword.
REQ-017 SHALL have port t2a_dwcnt, output, 12: dword index within the current FIS, 0-based.
REQ-018 SHALL have port r2t_rxempty, output, 1: receiver idle; consumed by the TX FSM.
REQ-019 SHALL have port r2t_waittxid, output, 1: one-cycle pulse on good DMA Activate; TX is to send a Data FIS.

Function
REQ-020 SHALL implement states IDLE, CTRL, DATA, DRAIN and STAT.
REQ-021 SHALL define a dword as accepted when lk_rxvalid & t2l_rxready.
REQ-022 SHALL, in IDLE, ignore accepted dwords without sof.
REQ-023 SHALL, in IDLE, on an accepted dword with sof, decode lk_rxdata[7:0]: 0x34, 0x39, 0x5F, 0x41, 0x58, 0xA1 -> CTRL; 0x46 -> DATA; any other value -> DRAIN with error flagged.
REQ-024 SHALL latch t2a_fistype at the sof dword.
REQ-025 SHALL use expected control lengths in dwords: RegD2H 5, DMAAct 1, PIOSetup 5, DMASetup 7, BIST 3, SDB 2.
REQ-026 SHALL set t2a_dwcnt to 0 on the sof dword and increment it per accepted dword.
REQ-027 SHALL hold t2a_dwcnt at 4095 without wrapping; overflow flags a length error.
REQ-028 SHALL, in CTRL, forward each accepted dword with t2a_dvalid=1 one cycle later.
REQ-029 SHALL, in CTRL, flag a length error if eof arrives at an index other than expected length-1, or if no eof arrives by that index; a missing eof causes DRAIN.
REQ-030 SHALL, in DATA, tie t2l_rxready to a2t_dready; in all other states t2l_rxready=1, except STAT where it is 0.
REQ-031 SHALL, in DATA, forward payload dwords at index>=1 with t2a_dvalid; the header dword is not forwarded.
REQ-032 SHALL, in DATA, flag a length error for eof at index 0 or for more than 2049 dwords.
REQ-033 SHALL, in DRAIN, discard dwords (t2a_dvalid=0) until eof.
REQ-034 SHALL go to STAT on an eof in any of CTRL, DATA or DRAIN.
REQ-035 SHALL, in STAT (one cycle), on a good FIS (no error and no crcerr) pulse t2l_rxgood and t2a_fisvalid, and pulse r2t_waittxid if the type is DMAAct.
REQ-036 SHALL, in STAT, on a bad FIS pulse t2l_rxbad and t2a_fiserr.
REQ-037 SHALL return from STAT to IDLE.
REQ-038 SHALL treat sof received outside IDLE as an error: abort to STAT with a bad result; that dword is consumed and not re-decoded.
REQ-039 SHALL drive r2t_rxempty=1 only in IDLE.
REQ-040 SHALL register all outputs except t2l_rxready and r2t_rxempty, which are decoded from state.

Reset
REQ-041 SHALL, while tprx_reset_n=0, force IDLE immediately: t2a_fistype=0, t2a_dwcnt=0, t2a_data=0, all pulses and t2a_dvalid=0, r2t_rxempty=1.
REQ-042 SHALL, on reset mid-FIS, discard the partial FIS with no status pulses; after release, non-sof dwords are ignored until the next sof.

Verification
REQ-043 SHALL be tested with RegD2H 0x34 plus 4 dwords, eof on the 5th, crcerr=0 -> 5 t2a_dvalid beats with dwcnt 0..4; STAT pulses t2l_rxgood, t2a_fisvalid; fistype=1.
REQ-044 SHALL be tested with DMAAct 0x39, sof and eof in the same dword -> t2l_rxgood, t2a_fisvalid, r2t_waittxid each pulse once; r2t_rxempty returns to 1.
REQ-045 SHALL be tested with Data 0x46 plus 8 dwords while a2t_dready toggles 1,0,1 -> t2l_rxready follows a2t_dready; exactly 8 payload beats in order; good status.
REQ-046 SHALL be tested with type 0x12 plus 3 dwords -> no t2a_dvalid; t2l_rxbad and t2a_fiserr pulse after eof.
REQ-047 SHALL be tested with PIOSetup eof at index 3 and with a RegD2H carrying crcerr=1 -> t2l_rxbad and t2a_fiserr for each; no fisvalid.
REQ-048 SHALL be tested with reset asserted at Data index 100 and a new RegD2H after release -> no status for the aborted FIS; the new FIS completes good.
